dtu_cred_arb: RTL
=================

Name: dtu_cred_arb

Overview:
Parametrised N-channel local credit arbiter for the DTU request path. It arbitrates round-robin across N_CH request queues and issues a request downstream only when the route capability permits the channel and the shared beat-credit pool covers the whole transfer. Credits come back as data beats leave on the AXI4S return path. It generalises the fixed single-destination host credit units and adds per-channel capability gating, drop accounting and credit-overflow detection.

Parameters:
N_CH, 4, number of request channels (>=2)
LEN_BITS, 28, request length width in bytes
DATA_BITS, 512, AXI4S data width; BEAT_BYTES = DATA_BITS/8
CRED_BEATS, 64, credit pool size in beats (power of two not required)
PID_BITS, 6, tid width
CH_BITS = max(1,$clog2(N_CH)), CRED_W = $clog2(CRED_BEATS+1) (derived, localparam)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
host_route_cap  in  N_CH  bit i=1 permits channel i
flush  in  1  1 = stop issuing new grants
s_req_valid  in  N_CH  per-channel request valid
s_req_ready  out  N_CH  per-channel accept
s_req_len  in  N_CH*LEN_BITS  channel i length at [i*LEN_BITS +: LEN_BITS]
m_req_valid  out  1  issued request valid
m_req_ready  in  1  downstream accept
m_req_chan  out  CH_BITS  issuing channel
m_req_len  out  LEN_BITS  issued length
s_axis_tvalid/tready/tdata/tkeep/tlast/tid  in/out/in/in/in/in  1/1/DATA_BITS/DATA_BITS/8/1/PID_BITS  return data in
m_axis_tvalid/tready/tdata/tkeep/tlast/tid  out/in/out/out/out/out  same widths  return data out
cred_avail  out  CRED_W  current credits
err_drop_cnt  out  16  dropped-request count, saturating
err_cred_ovf  out  1  sticky credit-overflow flag

Behaviour:
- Reset (async, aresetn=0): m_req_valid=0, m_req_chan=0, m_req_len=0, s_req_ready=0, cred_avail=CRED_BEATS, rr_ptr=0, err_drop_cnt=0, err_cred_ovf=0. Deasserting reset mid-transfer loses in-flight state; credits restart full.
- beats(i) = ceil(len_i / BEAT_BYTES), computed in LEN_BITS+1 width.
- Channel classes: BAD if cap bit 0, len=0, or beats>CRED_BEATS. OK if not BAD and beats<=cred_avail. Otherwise WAIT.
- Grant slot exists when !flush and (m_req_valid==0 or m_req_ready==1).
- Grant: first channel with valid and class OK or BAD, searching rr_ptr, rr_ptr+1, ... mod N_CH. Combinational select; at most one s_req_ready bit per cycle, asserted only in the grant cycle (one-hot, same-cycle handshake).
- Granted OK: next cycle m_req_valid=1 with chan/len registered, cred_avail -= beats. One-cycle latency from s_req handshake to m_req_valid.
- Granted BAD: accepted and discarded; err_drop_cnt+1 (saturate at 16'hFFFF); m_req register is not loaded (it is cleared if m_req_ready popped it).
- rr_ptr <= granted+1 mod N_CH after any grant; it is unchanged when there is no grant. WAIT channels never block others and receive no bypass.
- m_req holds stable while m_req_valid && !m_req_ready.
- Data path: m_axis_* = s_axis_* combinationally; s_axis_tready = m_axis_tready. Each m_axis handshake returns 1 credit.
- Simultaneous grant and return in one cycle: cred_next = cred - beats + 1.
- Overflow: a return that would push cred_next above CRED_BEATS clamps to CRED_BEATS and sets err_cred_ovf (cleared only by reset).
- flush=1: no new grants; the pending m_req still drains; credits still return.

Test Plan:
- Reset, CRED_BEATS=64: cap=4'hF, ch0 len=100 -> ch0 ready 1 cycle, next cycle m_req_valid chan=0 len=100, cred_avail=62.
- ch0..ch3 all valid, len=64, m_req_ready=1 -> grants in order 0,1,2,3,0; cred_avail falls by 1 per grant.
- cred_avail=2, ch1 len=200 (4 beats), ch2 len=64 -> ch2 granted, ch1 waits. After 2 m_axis beats, cred=3; after 1 more, ch1 granted and cred=0.
- cap=4'b1110, ch0 len=64 -> ch0 accepted, err_drop_cnt=1, no m_req_valid, cred unchanged. Same for ch1 len=0 and for len=64*65.
- Same cycle: grant of 2 beats and one m_axis beat with cred=10 -> cred=9. Extra beat at cred=64 -> cred stays 64, err_cred_ovf=1.
- m_req_ready=0 holds the issued request stable for 5 cycles with no further grants. flush=1 blocks new grants. aresetn pulse mid-hold -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dtu_cred_arb.sv
// N-channel round-robin request arbiter gated by route capability and a shared
// beat-credit pool; credits are refunded as beats leave on the AXI4S return path.
module dtu_cred_arb #(
  parameter int N_CH       = 4,
  parameter int LEN_BITS   = 28,
  parameter int DATA_BITS  = 512,
  parameter int CRED_BEATS = 64,
  parameter int PID_BITS   = 6,
  localparam int CH_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CRED_W    = $clog2(CRED_BEATS + 1)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CH-1:0]          host_route_cap,
  input  logic                     flush,
  input  logic [N_CH-1:0]          s_req_valid,
  output logic [N_CH-1:0]          s_req_ready,
  input  logic [N_CH*LEN_BITS-1:0] s_req_len,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [CH_BITS-1:0]       m_req_chan,
  output logic [LEN_BITS-1:0]      m_req_len,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_BITS-1:0]     s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [PID_BITS-1:0]      s_axis_tid,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_BITS-1:0]     m_axis_tdata,
  output logic [DATA_BITS/8-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [PID_BITS-1:0]      m_axis_tid,
  output logic [CRED_W-1:0]        cred_avail,
  output logic [15:0]              err_drop_cnt,
  output logic                     err_cred_ovf
);

  // Handshakes: a transfer happens on a rising aclk edge where valid && ready.
  // s_req_ready is combinational and one-hot, high only for the granted channel;
  // m_req holds its payload while m_req_valid && !m_req_ready.

  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam logic [LEN_BITS:0]   BB_L     = (LEN_BITS+1)'(BEAT_BYTES);
  localparam logic [LEN_BITS:0]   BB_M1_L  = (LEN_BITS+1)'(BEAT_BYTES - 1);
  localparam logic [LEN_BITS:0]   CRED_L   = (LEN_BITS+1)'(CRED_BEATS);
  localparam logic [CRED_W:0]     CRED_C   = (CRED_W+1)'(CRED_BEATS);
  localparam logic [CH_BITS-1:0]  LAST_CH  = CH_BITS'(N_CH - 1);

  logic [CRED_W-1:0]   cred_q, cred_d;
  logic [CH_BITS-1:0]  rr_q, rr_d;
  logic [15:0]         drop_q, drop_d;
  logic                ovf_q, ovf_d;
  logic                mv_q, mv_d;
  logic [CH_BITS-1:0]  chan_q, chan_d;
  logic [LEN_BITS-1:0] len_q, len_d;

  logic [LEN_BITS-1:0] len_a   [N_CH];
  logic [LEN_BITS:0]   beats_a [N_CH];
  logic [N_CH-1:0]     bad, ok;
  logic [LEN_BITS:0]   cred_ext;
  logic                slot, gnt_found, gnt_bad, grant_ok, ret;
  logic [CH_BITS-1:0]  gnt_idx, idx;
  logic [CRED_W:0]     gnt_cost, cred_sum;

  assign cred_ext = (LEN_BITS+1)'(cred_q);
  assign slot     = aresetn && !flush && (!mv_q || m_req_ready);
  assign ret      = s_axis_tvalid && m_axis_tready;

  // Channel classification: BAD requests are swallowed, OK ones fit the pool now.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      len_a[i]   = s_req_len[i*LEN_BITS +: LEN_BITS];
      beats_a[i] = ({1'b0, len_a[i]} + BB_M1_L) / BB_L;
      bad[i]     = !host_route_cap[i] || (len_a[i] == '0) || (beats_a[i] > CRED_L);
      ok[i]      = !bad[i] && (beats_a[i] <= cred_ext);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_bad   = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CH_BITS'((int'(rr_q) + k) % N_CH);
      if (!gnt_found && s_req_valid[idx] && (ok[idx] || bad[idx])) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
        gnt_bad   = bad[idx];
      end
    end
    if (!slot) gnt_found = 1'b0;
    s_req_ready = '0;
    if (gnt_found) s_req_ready[gnt_idx] = 1'b1;
  end

  assign grant_ok = gnt_found && !gnt_bad;
  assign gnt_cost = grant_ok ? (CRED_W+1)'(beats_a[gnt_idx]) : '0;
  assign cred_sum = {1'b0, cred_q} - gnt_cost + {{CRED_W{1'b0}}, ret};

  always_comb begin
    cred_d = cred_q;
    ovf_d  = ovf_q;
    rr_d   = rr_q;
    drop_d = drop_q;
    mv_d   = mv_q;
    chan_d = chan_q;
    len_d  = len_q;
    // A grant never overdraws, so only a surplus return can exceed the pool.
    if (cred_sum > CRED_C) begin
      cred_d = CRED_W'(CRED_BEATS);
      ovf_d  = 1'b1;
    end else begin
      cred_d = cred_sum[CRED_W-1:0];
    end
    if (mv_q && m_req_ready) mv_d = 1'b0;
    if (gnt_found) begin
      rr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      if (gnt_bad) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else begin
        mv_d   = 1'b1;
        chan_d = gnt_idx;
        len_d  = len_a[gnt_idx];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cred_q <= CRED_W'(CRED_BEATS);
      ovf_q  <= 1'b0;
      rr_q   <= '0;
      drop_q <= '0;
      mv_q   <= 1'b0;
      chan_q <= '0;
      len_q  <= '0;
    end else begin
      cred_q <= cred_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
      mv_q   <= mv_d;
      chan_q <= chan_d;
      len_q  <= len_d;
    end
  end

  assign m_req_valid   = mv_q;
  assign m_req_chan    = chan_q;
  assign m_req_len     = len_q;
  assign cred_avail    = cred_q;
  assign err_drop_cnt  = drop_q;
  assign err_cred_ovf  = ovf_q;

  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tid    = s_axis_tid;
  assign s_axis_tready = m_axis_tready;

endmodule
